// File: rtl/xilinx_dram_pkg.sv
// Shared types and constants for the LUTRAM read-side streaming engine.
package xilinx_dram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Only the two native LUTRAM column depths are supported.
  localparam int ABITS_DEPTH64  = 6;
  localparam int ABITS_DEPTH128 = 7;
  localparam int DEPTH64        = 64;
  localparam int DEPTH128       = 128;

  function automatic int depth_of(input int abits);
    return 1 << abits;
  endfunction

endpackage

// File: rtl/xilinx_dram_readout_if.sv
// Output stream of the readout engine: valid/ready handshake with end-of-burst flag.
interface xilinx_dram_readout_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xilinx_dram_readout_slot.sv
// Single-entry output register: captures a word when told to and holds it until accepted.
module xilinx_dram_readout_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             cap_last,
  output logic             free,
  xilinx_dram_readout_if.master m
);

  logic             valid_q;
  logic             last_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: registers use non-blocking assignments; data is reset too because the
  // outputs must read as zero during and after reset, not just invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      data_q  <= cap_data;
      last_q  <= cap_last;
    end else if (m.ready) begin
      valid_q <= 1'b0;
    end
  end

  // A new word may enter in the same cycle the held one leaves, so no bubble.
  assign free    = !valid_q || m.ready;
  assign m.valid = valid_q;
  assign m.data  = data_q;
  assign m.last  = last_q;

endmodule

// File: rtl/xilinx_dram_readout.sv
// Burst read engine for a LUTRAM array: walks the async read port over a wrapping window.
// Optional macro DRAM_READOUT_BYPASS_EN forwards same-address write data into the capture.
module xilinx_dram_readout
  import xilinx_dram_pkg::*;
#(
  parameter int ABITS = 6,
  parameter int WIDTH = 8
) (
  input  logic             CLK1,
  input  logic             RSTN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_base,
  input  logic [ABITS-1:0] cmd_len,
  output logic [ABITS-1:0] A1ADDR,
  input  logic [WIDTH-1:0] A1DATA,
  input  logic [ABITS-1:0] B1ADDR,
  input  logic [WIDTH-1:0] B1DATA,
  input  logic             B1EN,
  xilinx_dram_readout_if.master m,
  output logic             done
);

  localparam int DEPTH = depth_of(ABITS);

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [ABITS-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             capture, cap_last, slot_free, last_accept;
  logic [WIDTH-1:0] cap_data;

`ifdef DRAM_READOUT_BYPASS_EN
  assign cap_data = (B1EN && (B1ADDR == addr_q)) ? B1DATA : A1DATA;
`else
  // The LUTRAM write lands at the edge, so the read port still shows old contents.
  assign cap_data = A1DATA;
  logic unused_b1;
  assign unused_b1 = &{1'b0, B1EN, B1ADDR, B1DATA};
`endif

  assign last_accept = m.valid && m.ready && m.last;

  always_ff @(posedge CLK1 or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    cap_last  = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_base;
          rem_d   = cmd_len;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slot_free) begin
          capture  = 1'b1;
          cap_last = (rem_q == '0);
          if (rem_q == '0) begin
            state_d = DRAIN;
          end else begin
            addr_d = ABITS'((int'(addr_q) + 1) % DEPTH);
            rem_d  = rem_q - 1'b1;
          end
        end
      end
      DRAIN: begin
        // done is held for one cycle before returning, so cmd_ready follows done.
        if (done_q) begin
          state_d = IDLE;
        end else if (last_accept) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A1ADDR = addr_q;
  assign done   = done_q;

  xilinx_dram_readout_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk      (CLK1),
    .rst_n    (RSTN),
    .capture  (capture),
    .cap_data (cap_data),
    .cap_last (cap_last),
    .free     (slot_free),
    .m        (m)
  );

endmodule

// File: tb/tb_xilinx_dram_readout.sv
// Self-checking bench: a 64-deep and a 128-deep instance, each fed from a behavioural LUTRAM.
`timescale 1ns/1ps
module tb_xilinx_dram_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 64-deep instance
  logic       cmd_valid, cmd_ready, b1en, done;
  logic [5:0] cmd_base, cmd_len, a1addr, b1addr;
  logic [7:0] a1data, b1data;
  logic [7:0] ram6 [64];
  int         model6 [64];
  xilinx_dram_readout_if #(.WIDTH(8)) s6 ();

  assign a1data = ram6[a1addr];
  always @(posedge clk) if (b1en) ram6[b1addr] <= b1data;

  xilinx_dram_readout #(.ABITS(6), .WIDTH(8)) dut6 (
    .CLK1(clk), .RSTN(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .A1ADDR(a1addr), .A1DATA(a1data),
    .B1ADDR(b1addr), .B1DATA(b1data), .B1EN(b1en), .m(s6), .done(done));

  // 128-deep instance
  logic       cmd_valid7, cmd_ready7, b1en7, done7;
  logic [6:0] cmd_base7, cmd_len7, a1addr7, b1addr7;
  logic [7:0] a1data7, b1data7;
  logic [7:0] ram7 [128];
  int         model7 [128];
  xilinx_dram_readout_if #(.WIDTH(8)) s7 ();

  assign a1data7 = ram7[a1addr7];
  always @(posedge clk) if (b1en7) ram7[b1addr7] <= b1data7;

  xilinx_dram_readout #(.ABITS(7), .WIDTH(8)) dut7 (
    .CLK1(clk), .RSTN(rst_n), .cmd_valid(cmd_valid7), .cmd_ready(cmd_ready7),
    .cmd_base(cmd_base7), .cmd_len(cmd_len7), .A1ADDR(a1addr7), .A1DATA(a1data7),
    .B1ADDR(b1addr7), .B1DATA(b1data7), .B1EN(b1en7), .m(s7), .done(done7));

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load6(input bit rnd);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      b1en   = 1'b1;
      b1addr = 6'(i);
      b1data = rnd ? 8'($urandom) : 8'(i);
      model6[i] = int'(b1data);
    end
    @(negedge clk);
    b1en = 1'b0;
  endtask

  task automatic load7();
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      b1en7   = 1'b1;
      b1addr7 = 7'(i);
      b1data7 = 8'($urandom);
      model7[i] = int'(b1data7);
    end
    @(negedge clk);
    b1en7 = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for burst cycles 3..5.
  // coll_addr >= 0 writes 0xA5 to that address in the cycle it is captured.
  task automatic run6(input int base, input int len, input int mode, input int coll_addr,
                      input string tag);
    int idx = 0, cyc = 0, n_cap = 0, coll_idx, coll_exp = 0;
    bit holding = 1'b0, coll_done = 1'b0, cap_now;
    logic [7:0] h_data;
    logic       h_last;
    logic [5:0] h_addr;
    coll_idx = (coll_addr - base) & 63;
    @(negedge clk);
    check({tag, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_base  = 6'(base);
    cmd_len   = 6'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " cmd_ready busy"}, cmd_ready, 0);
    while (idx <= len && cyc < 2000) begin
      b1en = 1'b0;
      s6.ready = (mode == 0) ? 1'b1 :
                 (mode == 1) ? ($urandom_range(0, 99) >= 35) : !(cyc >= 3 && cyc <= 5);
      if (cyc == 0) check({tag, " m_valid low before latency"}, s6.valid, 0);
      if (cyc == 1) check({tag, " m_valid at 2-cycle latency"}, s6.valid, 1);
      if (mode == 0 && cyc >= 2) check({tag, " no bubble"}, s6.valid, 1);
      if (holding) begin
        check({tag, " held data"}, s6.data, h_data);
        check({tag, " held last"}, s6.last, h_last);
        check({tag, " addr stalled"}, a1addr, h_addr);
      end
      check({tag, " done low mid-burst"}, done, 0);
      holding = s6.valid && !s6.ready;
      h_data  = s6.data;
      h_last  = s6.last;
      h_addr  = a1addr;
      cap_now = (n_cap <= len) && (!s6.valid || s6.ready);
      if (cap_now) begin
        check({tag, " read address"}, a1addr, (base + n_cap) & 63);
        if (coll_addr >= 0 && !coll_done && int'(a1addr) == coll_addr) begin
          b1en   = 1'b1;
          b1addr = 6'(coll_addr);
          b1data = 8'hA5;
`ifdef DRAM_READOUT_BYPASS_EN
          coll_exp = 'hA5;
`else
          coll_exp = model6[coll_addr];
`endif
          model6[coll_addr] = 'hA5;
          coll_done = 1'b1;
        end
        n_cap++;
      end
      if (s6.valid && s6.ready) begin
        check({tag, " beat data"}, s6.data,
              (coll_done && idx == coll_idx) ? coll_exp : model6[(base + idx) & 63]);
        check({tag, " beat last"}, s6.last, (idx == len) ? 1 : 0);
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    b1en = 1'b0;
    check({tag, " beats delivered"}, idx, len + 1);
    check({tag, " done pulse"}, done, 1);
    check({tag, " cmd_ready during done"}, cmd_ready, 0);
    check({tag, " m_valid after last"}, s6.valid, 0);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " cmd_ready after done"}, cmd_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base7, idx7, cyc7;
    bit ready_seen;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; b1en = 1'b0; b1addr = '0; b1data = '0;
    cmd_valid7 = 1'b0; cmd_base7 = '0; cmd_len7 = '0; b1en7 = 1'b0; b1addr7 = '0; b1data7 = '0;
    s6.ready = 1'b1;
    s7.ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset m_valid", s6.valid, 0);
    check("reset m_data", s6.data, 0);
    check("reset m_last", s6.last, 0);
    check("reset done", done, 0);
    check("reset A1ADDR", a1addr, 0);
    rst_n = 1'b1;

    load6(1'b0);
    run6(5, 3, 0, -1, "basic");
    run6(62, 3, 0, -1, "wrap");
    run6(20, 7, 2, -1, "stall");
    run6(5, 3, 0, 7, "collision");

    // Reset while a burst is in flight.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 6'd10; cmd_len = 6'd20; s6.ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-burst valid before reset", s6.valid, 1);
    rst_n = 1'b0;
    #1;
    check("async reset m_valid", s6.valid, 0);
    check("async reset m_data", s6.data, 0);
    check("async reset m_last", s6.last, 0);
    check("async reset done", done, 0);
    check("async reset A1ADDR", a1addr, 0);
    check("async reset cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run6(0, 0, 0, -1, "post-reset single");

    load6(1'b1);
    for (int i = 0; i < 8; i++) begin
      run6(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1, -1, "random");
    end

    // Full-depth burst on the 128-deep instance.
    load7();
    base7 = int'($urandom_range(0, 127));
    @(negedge clk);
    check("full cmd_ready idle", cmd_ready7, 1);
    cmd_valid7 = 1'b1; cmd_base7 = 7'(base7); cmd_len7 = 7'd127; s7.ready = 1'b1;
    @(negedge clk);
    cmd_valid7 = 1'b0;
    idx7 = 0; cyc7 = 0; ready_seen = 1'b0;
    while (idx7 < 128 && cyc7 < 400) begin
      ready_seen |= cmd_ready7;
      if (s7.valid && s7.ready) begin
        check("full beat data", s7.data, model7[(base7 + idx7) & 127]);
        check("full beat last", s7.last, (idx7 == 127) ? 1 : 0);
        idx7++;
      end
      cyc7++;
      @(negedge clk);
    end
    check("full beats delivered", idx7, 128);
    check("full cmd_ready held low", ready_seen, 0);
    check("full done pulse", done7, 1);
    @(negedge clk);
    check("full done one cycle", done7, 0);
    check("full cmd_ready after done", cmd_ready7, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
